regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single write port of the MIPS32 register file between two writeback requesters: requester 0 is ALU writeback and requester 1 is load/memory writeback. Each requester has a one-entry holding buffer. When both buffers hold data, the older entry is granted first. The block drives the register file's write address, write data and write strobe from registers. It also raises a combinational stall when a pending write targets a register the decode stage is reading.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low; all state cleared while low
- req0_valid  in  1  requester 0 has a write
- req0_ready  out  1  requester 0 buffer can accept
- req0_addr  in  ADDR_W  requester 0 destination register
- req0_data  in  DATA_W  requester 0 write data
- req1_valid / req1_ready / req1_addr / req1_data  as requester 0, for requester 1
- rd_addr_a  in  ADDR_W  decode read index (rs)
- rd_addr_b  in  ADDR_W  decode read index (rt)
- stall  out  1  read/pending-write hazard, combinational
- rf_we_addr  out  ADDR_W  register file write index, registered
- rf_wdata  out  DATA_W  register file write data, registered
- rf_write  out  1  register file write strobe, registered, one cycle per commit
- grant_id  out  1  source of the current commit (0 or 1), registered

## Operation
- Per-requester state: full_i, addr_i, data_i. A shared age bit `older` records which buffer was loaded first; it is meaningful only when both buffers are full.
- Accept rule: req_i_ready = rst & (!full_i | commit_i). A transfer happens at an edge where valid & ready are both high. On a transfer the buffer loads addr/data and full_i is set.
- Arbitration is combinational on buffer state.
  - Exactly one buffer full: grant it.
  - Both full: grant `older`.
  - Both loaded at the same edge: grant !last_grant, the round-robin pointer.
- Commit: at the edge following arbitration, the output registers load the granted buffer's addr/data and rf_write=1.
  - grant_id and last_grant take the granted index.
  - The granted buffer clears unless it is refilled at the same edge; simultaneous drain and refill is legal and keeps full_i=1.
- No buffer full: rf_write=0 at the next edge. rf_we_addr, rf_wdata and grant_id hold their values.
- At most one commit per cycle, so sustained throughput is one write per cycle total.
- Ordering:
  - Per-requester order is preserved because each requester has a single buffer.
  - Cross-requester order follows acceptance order. Same-edge acceptance is ordered round-robin.
- stall = 1 if rd_addr_a or rd_addr_b equals any of:
  - addr_i of a full buffer;
  - rf_we_addr while rf_write=1.

## Timing
- Reset values: rf_write=0, rf_we_addr=0, rf_wdata=0, grant_id=0, full0=full1=0, older=0, last_grant=1 (requester 0 wins the first tie), req*_ready=0 while rst low, stall=0.
- Latency, uncontended: accepted at edge k, rf_write high in cycle k+1, register file captures at edge k+2.
- Contended: the losing entry commits one cycle later, at edge k+2, with rf_write high in cycle k+2.
- Reset asserted mid-operation discards buffered writes; rf_write drops immediately.
- Deassertion of reset is assumed synchronous to clk at system level. Ready rises combinationally with rst.

## Configuration
- REGARB_ZERO_FILTER_EN defined:
  - writes to register 0 complete the handshake but are not buffered;
  - they never produce rf_write and never win arbitration;
  - rd_addr_a/b = 0 never causes stall.
- REGARB_ZERO_FILTER_EN undefined: register 0 is treated like any other index. The register file itself ignores the write.

## Test plan
- Reset: hold rst=0 with req0_valid=1 -> req0_ready=0, rf_write=0, all outputs 0. Release rst -> req0_ready=1.
- Single write: req0 addr=8 data=0xDEADBEEF for one cycle -> one cycle later rf_write=1, rf_we_addr=8, rf_wdata=0xDEADBEEF, grant_id=0. Next cycle rf_write=0.
- Same-edge tie: req0 (addr 3, 0x11) and req1 (addr 4, 0x22) accepted together after reset -> req0 commits first, req1 the following cycle. Repeat the tie -> req1 commits first.
- Age ordering: req1 addr=5 accepted one edge before req0 addr=5, with the output held busy by a prior commit -> req1's data commits before req0's. The final register value is req0's.
- Hazard: buffer req1 addr=9 and drive rd_addr_a=9 -> stall=1 until the cycle after rf_write for addr 9, then 0. rd_addr_b=10 alone -> stall=0.
- Back-to-back and zero filter: req0_valid held high for 4 cycles with addrs 1,2,3,0 -> ready stays 1 and commits occur in consecutive cycles. With REGARB_ZERO_FILTER_EN defined, addr 0 produces no rf_write. With it undefined, addr 0 commits.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single write port of the MIPS32 register file between two
// writeback requesters: requester 0 (ALU writeback) and requester 1
// (load/memory writeback). Each requester owns a one-entry holding buffer.
// When both buffers are occupied, the entry that was loaded first commits
// first. When both were loaded on the same edge, a round-robin pointer picks
// the winner. The register file write port is driven from registers.
// A combinational stall flags decode reads that hit a pending write.
//
// Optional feature macro: REGARB_ZERO_FILTER_EN
//   defined   - writes to register 0 complete their handshake but are
//               dropped; reads of register 0 never stall.
//   undefined - register 0 is handled like any other index.
//
// Ports:
//   clk                      clock, rising edge
//   rst                      asynchronous reset, active low
//   req0_valid/ready/addr/data  requester 0 (ALU) write handshake
//   req1_valid/ready/addr/data  requester 1 (load) write handshake
//   rd_addr_a, rd_addr_b     decode stage read indices (rs, rt)
//   stall                    read hits a pending/in-flight write (comb)
//   rf_we_addr, rf_wdata     register file write index/data (registered)
//   rf_write                 register file write strobe (registered)
//   grant_id                 source of the current commit (registered)
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              stall,
    output logic [ADDR_W-1:0] rf_we_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_write,
    output logic              grant_id
);

    // Holding buffers
    logic              full0_q, full0_d;
    logic              full1_q, full1_d;
    logic [ADDR_W-1:0] addr0_q, addr0_d;
    logic [ADDR_W-1:0] addr1_q, addr1_d;
    logic [DATA_W-1:0] data0_q, data0_d;
    logic [DATA_W-1:0] data1_q, data1_d;

    // Ordering state: older_q names the earlier-loaded buffer (only meaningful
    // when both are full); last_grant_q is the round-robin pointer.
    logic              older_q, older_d;
    logic              last_grant_q, last_grant_d;

    // Output registers
    logic              rf_write_q, rf_write_d;
    logic [ADDR_W-1:0] rf_we_addr_q, rf_we_addr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              grant_id_q, grant_id_d;

    logic any_full;
    logic grant_sel;
    logic commit0, commit1;
    logic load0, load1;
    logic keep0, keep1;
    logic rd_a_ok, rd_b_ok;
    logic hit_a, hit_b;

`ifdef REGARB_ZERO_FILTER_EN
    // Register 0 is hardwired to zero: accept such writes but never buffer them.
    assign keep0   = (req0_addr != '0);
    assign keep1   = (req1_addr != '0);
    assign rd_a_ok = (rd_addr_a != '0);
    assign rd_b_ok = (rd_addr_b != '0);
`else
    assign keep0   = 1'b1;
    assign keep1   = 1'b1;
    assign rd_a_ok = 1'b1;
    assign rd_b_ok = 1'b1;
`endif

    // Arbitration: a lone full buffer wins; with both full the older one wins.
    // A same-edge load encodes its round-robin winner into older_q, so no
    // separate tie flag is needed here.
    always_comb begin
        any_full  = full0_q | full1_q;
        grant_sel = (full0_q & full1_q) ? older_q : full1_q;
        commit0   = full0_q & ~grant_sel;
        commit1   = full1_q & grant_sel;
    end

    // A buffer can accept while empty or while it is draining this cycle.
    assign req0_ready = rst & (~full0_q | commit0);
    assign req1_ready = rst & (~full1_q | commit1);
    assign load0      = req0_valid & req0_ready & keep0;
    assign load1      = req1_valid & req1_ready & keep1;

    always_comb begin
        full0_d = load0 | (full0_q & ~commit0);
        full1_d = load1 | (full1_q & ~commit1);
        addr0_d = load0 ? req0_addr : addr0_q;
        data0_d = load0 ? req0_data : data0_q;
        addr1_d = load1 ? req1_addr : addr1_q;
        data1_d = load1 ? req1_data : data1_q;

        last_grant_d = any_full ? grant_sel : last_grant_q;

        // Both loaded together: the requester that did not win last goes first,
        // judged against the pointer as updated by this edge's commit.
        if (load0 && load1) begin
            older_d = ~last_grant_d;
        end else if (load0) begin
            older_d = 1'b1;
        end else if (load1) begin
            older_d = 1'b0;
        end else begin
            older_d = older_q;
        end

        rf_write_d   = any_full;
        rf_we_addr_d = rf_we_addr_q;
        rf_wdata_d   = rf_wdata_q;
        grant_id_d   = grant_id_q;
        if (any_full) begin
            rf_we_addr_d = grant_sel ? addr1_q : addr0_q;
            rf_wdata_d   = grant_sel ? data1_q : data0_q;
            grant_id_d   = grant_sel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full0_q      <= 1'b0;
            full1_q      <= 1'b0;
            addr0_q      <= '0;
            addr1_q      <= '0;
            data0_q      <= '0;
            data1_q      <= '0;
            older_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rf_write_q   <= 1'b0;
            rf_we_addr_q <= '0;
            rf_wdata_q   <= '0;
            grant_id_q   <= 1'b0;
        end else begin
            full0_q      <= full0_d;
            full1_q      <= full1_d;
            addr0_q      <= addr0_d;
            addr1_q      <= addr1_d;
            data0_q      <= data0_d;
            data1_q      <= data1_d;
            older_q      <= older_d;
            last_grant_q <= last_grant_d;
            rf_write_q   <= rf_write_d;
            rf_we_addr_q <= rf_we_addr_d;
            rf_wdata_q   <= rf_wdata_d;
            grant_id_q   <= grant_id_d;
        end
    end

    // Hazard: a decode read matches a buffered write or the write in flight.
    always_comb begin
        hit_a = rd_a_ok & ((full0_q & (rd_addr_a == addr0_q)) |
                           (full1_q & (rd_addr_a == addr1_q)) |
                           (rf_write_q & (rd_addr_a == rf_we_addr_q)));
        hit_b = rd_b_ok & ((full0_q & (rd_addr_b == addr0_q)) |
                           (full1_q & (rd_addr_b == addr1_q)) |
                           (rf_write_q & (rd_addr_b == rf_we_addr_q)));
    end

    assign stall      = hit_a | hit_b;
    assign rf_write   = rf_write_q;
    assign rf_we_addr = rf_we_addr_q;
    assign rf_wdata   = rf_wdata_q;
    assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Directed bench for regfile_write_arbiter. A queue-based model holds pending
// writes in acceptance order and retires the oldest one per cycle; a forked
// compare thread checks every DUT output against it on each falling edge.
// Hand-computed literal expectations pin the model at key points.
// Honours REGARB_ZERO_FILTER_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;
`ifdef REGARB_ZERO_FILTER_EN
   localparam bit ZF = 1'b1;
`else
   localparam bit ZF = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          req0_valid, req1_valid;
   logic          req0_ready, req1_ready;
   logic [AW-1:0] req0_addr, req1_addr;
   logic [DW-1:0] req0_data, req1_data;
   logic [AW-1:0] rd_addr_a, rd_addr_b;
   logic          stall;
   logic [AW-1:0] rf_we_addr;
   logic [DW-1:0] rf_wdata;
   logic          rf_write;
   logic          grant_id;

   regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_addr  (req0_addr),
      .req0_data  (req0_data),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_addr  (req1_addr),
      .req1_data  (req1_data),
      .rd_addr_a  (rd_addr_a),
      .rd_addr_b  (rd_addr_b),
      .stall      (stall),
      .rf_we_addr (rf_we_addr),
      .rf_wdata   (rf_wdata),
      .rf_write   (rf_write),
      .grant_id   (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: pending writes in the order they must reach the register file.
   typedef struct {
      int            src;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } entry_t;

   entry_t        pend[$];
   entry_t        head;
   logic          mRfWrite = 1'b0;
   logic [AW-1:0] mAddr = '0;
   logic [DW-1:0] mData = '0;
   int            mGrant = 0;
   int            mLast = 1;
   bit            acc0, acc1;

   int nVectors = 0;
   int nMiscompares = 0;

   // A requester may hand over a write unless it already has one waiting
   // behind the entry that retires this cycle.
   function automatic logic mReady(input int src);
      if (!rst) return 1'b0;
      for (int k = 1; k < pend.size(); k++)
         if (pend[k].src == src) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic mHit(input logic [AW-1:0] ra);
      if (ZF && ra == '0) return 1'b0;
      foreach (pend[k])
         if (pend[k].addr == ra) return 1'b1;
      return mRfWrite && (mAddr == ra);
   endfunction

   task automatic mPush(input int src, input logic [AW-1:0] a, input logic [DW-1:0] d);
      entry_t e;
      if (!(ZF && a == '0)) begin
         e.src  = src;
         e.addr = a;
         e.data = d;
         pend.push_back(e);
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend.delete();
         mRfWrite = 1'b0;
         mAddr    = '0;
         mData    = '0;
         mGrant   = 0;
         mLast    = 1;
      end else begin
         acc0 = req0_valid && mReady(0);
         acc1 = req1_valid && mReady(1);
         if (pend.size() > 0) begin
            head     = pend.pop_front();
            mRfWrite = 1'b1;
            mAddr    = head.addr;
            mData    = head.data;
            mGrant   = head.src;
            mLast    = head.src;
         end else begin
            mRfWrite = 1'b0;
         end
         if (acc0 && acc1) begin
            if (mLast == 1) begin
               mPush(0, req0_addr, req0_data);
               mPush(1, req1_addr, req1_data);
            end else begin
               mPush(1, req1_addr, req1_data);
               mPush(0, req0_addr, req0_data);
            end
         end else if (acc0) begin
            mPush(0, req0_addr, req0_data);
         end else if (acc1) begin
            mPush(1, req1_addr, req1_data);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nVectors++;
      if (actual !== expected) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic compareAll();
      checkOutput("model.req0_ready", 32'(req0_ready), 32'(mReady(0)));
      checkOutput("model.req1_ready", 32'(req1_ready), 32'(mReady(1)));
      checkOutput("model.stall", 32'(stall), 32'(mHit(rd_addr_a) || mHit(rd_addr_b)));
      checkOutput("model.rf_write", 32'(rf_write), 32'(mRfWrite));
      checkOutput("model.rf_we_addr", 32'(rf_we_addr), 32'(mAddr));
      checkOutput("model.rf_wdata", rf_wdata, mData);
      checkOutput("model.grant_id", 32'(grant_id), 32'(mGrant));
   endtask

   task automatic checkCommit(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic g);
      checkOutput({tag, ".rf_write"}, 32'(rf_write), 32'd1);
      checkOutput({tag, ".rf_we_addr"}, 32'(rf_we_addr), 32'(a));
      checkOutput({tag, ".rf_wdata"}, rf_wdata, d);
      checkOutput({tag, ".grant_id"}, 32'(grant_id), 32'(g));
   endtask

   // Waits for a rising edge, then drives the inputs sampled at the next one.
   task automatic applyStimulus(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                input logic [AW-1:0] ra, input logic [AW-1:0] rb);
      @(posedge clk);
      #1;
      req0_valid = v0;
      req0_addr  = a0;
      req0_data  = d0;
      req1_valid = v1;
      req1_addr  = a1;
      req1_data  = d1;
      rd_addr_a  = ra;
      rd_addr_b  = rb;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd30, 5'd31);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst        = 1'b1;
      req0_valid = 1'b0;
      req0_addr  = '0;
      req0_data  = '0;
      req1_valid = 1'b0;
      req1_addr  = '0;
      req1_data  = '0;
      rd_addr_a  = 5'd30;
      rd_addr_b  = 5'd31;
      #2 rst = 1'b0;

      fork
         forever begin
            @(negedge clk);
            compareAll();
         end
      join_none

      // Reset held with a request pending
      applyStimulus(1'b1, 5'd8, 32'h1, 1'b0, 5'd0, 32'h0, 5'd30, 5'd31);
      applyStimulus(1'b1, 5'd8, 32'h1, 1'b0, 5'd0, 32'h0, 5'd30, 5'd31);
      @(negedge clk);
      checkOutput("rst.req0_ready", 32'(req0_ready), 32'd0);
      checkOutput("rst.req1_ready", 32'(req1_ready), 32'd0);
      checkOutput("rst.rf_write", 32'(rf_write), 32'd0);
      checkOutput("rst.rf_we_addr", 32'(rf_we_addr), 32'd0);
      checkOutput("rst.rf_wdata", rf_wdata, 32'd0);
      checkOutput("rst.grant_id", 32'(grant_id), 32'd0);
      checkOutput("rst.stall", 32'(stall), 32'd0);
      idle();
      rst = 1'b1;
      @(negedge clk);
      checkOutput("release.req0_ready", 32'(req0_ready), 32'd1);
      checkOutput("release.req1_ready", 32'(req1_ready), 32'd1);

      // Single uncontended write
      applyStimulus(1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd30, 5'd31);
      idle();
      @(negedge clk);
      checkOutput("single.buffered.rf_write", 32'(rf_write), 32'd0);
      idle();
      @(negedge clk);
      checkCommit("single", 5'd8, 32'hDEADBEEF, 1'b0);
      idle();
      @(negedge clk);
      checkOutput("single.after.rf_write", 32'(rf_write), 32'd0);

      // Reset pulse restores the round-robin pointer
      idle();
      rst = 1'b0;
      idle();
      rst = 1'b1;

      // Same-edge tie after reset: requester 0 first
      applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd30, 5'd31);
      idle();
      @(negedge clk);
      checkOutput("tie1.req0_ready", 32'(req0_ready), 32'd1);
      checkOutput("tie1.req1_ready", 32'(req1_ready), 32'd0);
      idle();
      @(negedge clk);
      checkCommit("tie1.first", 5'd3, 32'h11, 1'b0);
      idle();
      @(negedge clk);
      checkCommit("tie1.second", 5'd4, 32'h22, 1'b1);

      // Requester 0 commits, then a tie lands while it drains: requester 1 first
      applyStimulus(1'b1, 5'd2, 32'h33, 1'b0, 5'd0, 32'h0, 5'd30, 5'd31);
      applyStimulus(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h44, 5'd30, 5'd31);
      idle();
      @(negedge clk);
      checkCommit("tie2.lead", 5'd2, 32'h33, 1'b0);
      idle();
      @(negedge clk);
      checkCommit("tie2.first", 5'd6, 32'h44, 1'b1);
      idle();
      @(negedge clk);
      checkCommit("tie2.second", 5'd5, 32'h55, 1'b0);

      // Age ordering: req1 addr 5 accepted one edge before req0 addr 5
      applyStimulus(1'b1, 5'd12, 32'hA0, 1'b1, 5'd13, 32'hB0, 5'd30, 5'd31);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h0A, 5'd30, 5'd31);
      applyStimulus(1'b1, 5'd5, 32'h0B, 1'b0, 5'd0, 32'h0, 5'd30, 5'd31);
      @(negedge clk);
      checkCommit("age.busy1", 5'd13, 32'hB0, 1'b1);
      idle();
      @(negedge clk);
      checkCommit("age.busy2", 5'd12, 32'hA0, 1'b0);
      idle();
      @(negedge clk);
      checkCommit("age.older", 5'd5, 32'h0A, 1'b1);
      idle();
      @(negedge clk);
      checkCommit("age.younger", 5'd5, 32'h0B, 1'b0);
      idle();
      @(negedge clk);
      checkOutput("age.done.rf_write", 32'(rf_write), 32'd0);

      // Hazard on rd_addr_a through the buffer, then the in-flight write
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 5'd9, 5'd10);
      @(negedge clk);
      checkOutput("haz.before.stall", 32'(stall), 32'd0);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd10);
      @(negedge clk);
      checkOutput("haz.buffered.stall", 32'(stall), 32'd1);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd10);
      @(negedge clk);
      checkOutput("haz.inflight.stall", 32'(stall), 32'd1);
      checkCommit("haz.commit", 5'd9, 32'h99, 1'b1);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd10);
      @(negedge clk);
      checkOutput("haz.cleared.stall", 32'(stall), 32'd0);

      // rd_addr_b=10 alone against buffered 9, then rd_addr_b hits in flight
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h98, 5'd31, 5'd10);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd10);
      @(negedge clk);
      checkOutput("haz.noalias.stall", 32'(stall), 32'd0);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd9);
      @(negedge clk);
      checkOutput("haz.portb.stall", 32'(stall), 32'd1);
      idle();
      @(negedge clk);
      checkOutput("haz.portb.cleared", 32'(stall), 32'd0);

      // Back-to-back writes from requester 0, last one to register 0
      applyStimulus(1'b1, 5'd1, 32'hA1, 1'b0, 5'd0, 32'h0, 5'd30, 5'd31);
      applyStimulus(1'b1, 5'd2, 32'hA2, 1'b0, 5'd0, 32'h0, 5'd30, 5'd31);
      @(negedge clk);
      checkOutput("b2b.ready.1", 32'(req0_ready), 32'd1);
      applyStimulus(1'b1, 5'd3, 32'hA3, 1'b0, 5'd0, 32'h0, 5'd30, 5'd31);
      @(negedge clk);
      checkOutput("b2b.ready.2", 32'(req0_ready), 32'd1);
      checkCommit("b2b.w1", 5'd1, 32'hA1, 1'b0);
      applyStimulus(1'b1, 5'd0, 32'hA0, 1'b0, 5'd0, 32'h0, 5'd30, 5'd31);
      @(negedge clk);
      checkOutput("b2b.ready.3", 32'(req0_ready), 32'd1);
      checkCommit("b2b.w2", 5'd2, 32'hA2, 1'b0);
      idle();
      @(negedge clk);
      checkCommit("b2b.w3", 5'd3, 32'hA3, 1'b0);
      idle();
      @(negedge clk);
`ifdef REGARB_ZERO_FILTER_EN
      checkOutput("b2b.zero.rf_write", 32'(rf_write), 32'd0);
      checkOutput("b2b.zero.rf_we_addr", 32'(rf_we_addr), 32'd3);
`else
      checkCommit("b2b.zero", 5'd0, 32'hA0, 1'b0);
`endif
      idle();
      @(negedge clk);
      checkOutput("b2b.done.rf_write", 32'(rf_write), 32'd0);

      // Reset mid-operation discards the buffered loser and drops rf_write
      applyStimulus(1'b1, 5'd7, 32'h77, 1'b1, 5'd17, 32'h71, 5'd30, 5'd31);
      idle();
      idle();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst.rf_write", 32'(rf_write), 32'd0);
      checkOutput("midrst.rf_we_addr", 32'(rf_we_addr), 32'd0);
      checkOutput("midrst.req0_ready", 32'(req0_ready), 32'd0);
      idle();
      rst = 1'b1;
      idle();
      @(negedge clk);
      checkOutput("midrst.discarded.rf_write", 32'(rf_write), 32'd0);
      checkOutput("midrst.req1_ready", 32'(req1_ready), 32'd1);
      idle();
      idle();
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
